// File: rtl/dmem_wr_sched.sv
//============================================================================
// Module   : dmem_wr_sched
// Brief    : Round-robin write scheduler in front of one data-memory write
//            port. Up to NREQ requesters offer writes over valid/ready; at
//            most one is granted per cycle and the chosen address/data are
//            presented to the memory from a register, one cycle after the
//            handshake.
// Options  : DMEM_WR_STATS_EN - when defined, stall_count is a saturating
//            count of congested cycles; otherwise it is tied to zero.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module dmem_wr_sched #(
  parameter int NREQ   = 4,
  parameter int PTR_W  = 2,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]        mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic                     mem_wr_enable,
  output logic                     busy,
  output logic [15:0]              stall_count
);

  localparam logic [PTR_W:0]   c_NREQ_EXT = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(NREQ-1);

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [NREQ-1:0]    w_ready;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [DATA_W-1:0]  w_gnt_data;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  // Pick the first valid requester scanning from the pointer, with wrap.
  always_comb begin
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_ready   = '0;
    w_sum     = '0;
    w_idx     = '0;
    if (!reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
        if (w_sum >= c_NREQ_EXT) begin
          w_sum = w_sum - c_NREQ_EXT;
        end
        w_idx = w_sum[PTR_W-1:0];
        if (!w_gnt && req_valid[w_idx]) begin
          w_gnt     = 1'b1;
          w_gnt_idx = w_idx;
        end
      end
    end
    if (w_gnt) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Select the granted requester's address/data with constant slices.
  always_comb begin
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == PTR_W'(i)) begin
        w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer is one past the winner; wrap explicitly for non-power-of-2 NREQ.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_gnt) begin
      w_ptr_nxt = (w_gnt_idx == c_LAST_IDX) ? '0 : (w_gnt_idx + PTR_W'(1));
    end
  end

  // Round-robin pointer register; frozen whenever nothing is granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Registered write port; address/data hold their last values when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_gnt;
      if (w_gnt) begin
        r_wr_addr <= w_gnt_addr;
        r_wr_data <= w_gnt_data;
      end
    end
  end

  assign req_ready     = w_ready;
  assign mem_wr_enable = r_wr_en;
  assign mem_wr_addr   = r_wr_addr;
  assign mem_wr_data   = r_wr_data;
  assign busy          = (|req_valid) | r_wr_en;

`ifdef DMEM_WR_STATS_EN
  logic        w_multi;
  logic        w_stall;
  logic [15:0] r_stall_cnt;

  // Congested cycle: someone waits with no grant, or several compete.
  assign w_multi = |(req_valid & (req_valid - NREQ'(1)));
  assign w_stall = ((|req_valid) && !w_gnt) || w_multi;

  // Saturating stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: doc/dmem_wr_sched.md
Name: dmem_wr_sched

Overview:
- Round-robin write scheduler in front of one write port (wrN/wrN_data/wrN_enable) of the data memory.
- Collects write requests from up to NREQ pipeline requesters (execute, store buffer, debug, DMA) over valid/ready handshakes.
- Grants at most one request per cycle and drives the memory write port from a register, so the memory sees a clean, registered, single-writer stream.

Parameters:
- NREQ, 4, number of requesters; supported 2..8.
- PTR_W, 2, width of the round-robin pointer; 2**PTR_W >= NREQ.
- ADDR_W, 9, memory word address width.
- DATA_W, 32, memory word width.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising clock edge.
- hold  input  1  pause; no grants while high.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- mem_wr_addr  output  ADDR_W  to memory write address.
- mem_wr_data  output  DATA_W  to memory write data.
- mem_wr_enable  output  1  to memory write enable.
- busy  output  1  high when any req_valid is high or mem_wr_enable is high.
- stall_count  output  16  stall statistic; see Optional Feature.

Behaviour:
- Reset (reset=1 at a clock edge):
  - ptr <= 0; mem_wr_enable <= 0; mem_wr_addr <= 0; mem_wr_data <= 0; stall_count <= 0.
  - req_ready is forced to 0 combinationally while reset=1.
  - A reset arriving while a write sits in the output register drops that write: mem_wr_enable is 0 in the next cycle.
- Grant (combinational):
  - If hold=0 and reset=0, req_ready[g]=1 for the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ. All other bits are 0.
  - No valid request gives req_ready=0.
  - req_ready never depends on the requester's own ready, so there is no combinational loop.
- Pointer update:
  - After a grant to g: ptr <= (g+1) mod NREQ. The wrap is explicit for NREQ that is not a power of two, e.g. NREQ=3, g=2 gives ptr=0.
  - No grant: ptr holds.
- Output register:
  - On a grant to g: mem_wr_enable <= 1, mem_wr_addr <= addr[g], mem_wr_data <= data[g].
  - Otherwise: mem_wr_enable <= 0, and addr/data hold their last values.
  - Latency is exactly 1 cycle from handshake to the memory write strobe. Throughput is 1 write per cycle.
- Requester rules:
  - valid, addr and data stay stable until the handshake.
  - A requester may deassert valid only after being granted.
  - A request that stays pending is granted within NREQ cycles of hold going low (fairness bound).
- hold:
  - hold=1 blocks new grants; ptr is frozen.
  - A write already in the output register still completes in the following cycle.
- Same-address writes:
  - Two requesters targeting the same address are serialised in grant order; the last granted data persists.
  - The scheduler neither merges nor reorders these writes.

Optional Feature:
- DMEM_WR_STATS_EN defined:
  - stall_count increments by 1 on every cycle where (|req_valid) and no grant occurs, or where more than one req_valid bit is high. This counts cycles, not requests.
  - The counter saturates at 16'hFFFF and clears on reset.
- DMEM_WR_STATS_EN undefined:
  - stall_count is tied to 16'h0000 and no counter flops exist.

Test Plan:
- Reset: drive reset=1 for 2 cycles with all req_valid=4'b1111 -> req_ready=0, mem_wr_enable=0, addr/data=0; first cycle after release grants requester 0.
- Single requester: req_valid=4'b0100, addr[2]=9'h1A5, data[2]=32'hDEADBEEF -> req_ready=4'b0100 the same cycle; next cycle mem_wr_enable=1, mem_wr_addr=9'h1A5, mem_wr_data=32'hDEADBEEF; ptr=3.
- Round-robin: all four valid continuously -> grant order 0,1,2,3,0 over 5 cycles with mem_wr_enable high every cycle from cycle 2.
- Pointer wrap / hold: ptr=3, req_valid=4'b1001, hold=1 for 3 cycles -> no ready, mem_wr_enable=0, ptr stays 3; hold=0 -> grants 3 then 0.
- Same address: requesters 1 and 2 both write addr 9'h010 with 32'h11111111 and 32'h22222222, ptr=1 -> two consecutive writes in that order; final memory value 32'h22222222.
- Stats (macro on): req_valid=4'b0011 held for 1 cycle with hold=0, then hold=1 for 4 cycles -> stall_count=5; preload near 16'hFFFF and continue stalling -> stays 16'hFFFF.
